// File: rtl/msrv32_irq_arbiter.sv
// msrv32_irq_arbiter: edge-captured, masked external-interrupt arbiter with claim/complete handshake.
// Optional round-robin priority when IRQ_ARB_RR_PRIORITY_EN is defined (fixed lowest-index otherwise).
module msrv32_irq_arbiter #(
    parameter int NUM_SRC = 8,
    parameter int ID_W    = 4
) (
    input  logic               ms_riscv32_mp_clk_in,
    input  logic               ms_riscv32_mp_rst_in,
    input  logic [NUM_SRC-1:0] src_in,
    input  logic               enable_we_in,
    input  logic [NUM_SRC-1:0] enable_wdata_in,
    output logic [NUM_SRC-1:0] enable_out,
    output logic [NUM_SRC-1:0] pending_out,
    input  logic               claim_in,
    output logic               claim_ack_out,
    output logic [ID_W-1:0]    claim_id_out,
    input  logic               complete_in,
    input  logic [ID_W-1:0]    complete_id_in,
    output logic               eirq_out,
    output logic               busy_out
);
    typedef enum logic [1:0] {IDLE, ARMED, SERVICE} state_t;
    state_t             state_q;
    logic [NUM_SRC-1:0] src_q, pending_q, pending_d, enable_q, eligible, rise, clr;
    logic [ID_W-1:0]    claim_id_q, service_id_q, win_idx, win_id;
    logic               claim_ack_q, eirq_q, busy_q, any_elig, claim_ok;
`ifdef IRQ_ARB_RR_PRIORITY_EN
    logic [ID_W-1:0]    ptr_q;
`endif
    assign enable_out    = enable_q;
    assign pending_out   = pending_q;
    assign claim_ack_out = claim_ack_q;
    assign claim_id_out  = claim_id_q;
    assign eirq_out      = eirq_q;
    assign busy_out      = busy_q;
    // Edge detect, eligibility, winner select and pending next-state (a new rise beats a claim clear)
    always_comb begin
        rise     = src_in & ~src_q;
        eligible = pending_q & enable_q;
        any_elig = |eligible;
        win_idx  = '0;
`ifdef IRQ_ARB_RR_PRIORITY_EN
        for (int j = NUM_SRC - 1; j >= 0; j--)
            if (eligible[(int'(ptr_q) + j) % NUM_SRC]) win_idx = ID_W'((int'(ptr_q) + j) % NUM_SRC);
`else
        for (int i = NUM_SRC - 1; i >= 0; i--)
            if (eligible[i]) win_idx = ID_W'(i);
`endif
        win_id    = win_idx + 1'b1;
        claim_ok  = claim_in && state_q == ARMED && any_elig;
        clr       = claim_ok ? (NUM_SRC'(1) << win_idx) : '0;
        pending_d = (pending_q & ~clr) | rise;
    end
    // Capture, mask, claim/complete state machine with registered outputs
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            // A line already high during reset is not treated as a fresh edge afterwards
            src_q        <= src_in;
            pending_q    <= '0;
            enable_q     <= '0;
            claim_id_q   <= '0;
            claim_ack_q  <= 1'b0;
            eirq_q       <= 1'b0;
            busy_q       <= 1'b0;
            service_id_q <= '0;
            state_q      <= IDLE;
`ifdef IRQ_ARB_RR_PRIORITY_EN
            ptr_q        <= '0;
`endif
        end else begin
            src_q       <= src_in;
            pending_q   <= pending_d;
            claim_ack_q <= claim_in;
            if (enable_we_in) enable_q <= enable_wdata_in;
            if (claim_in) claim_id_q <= claim_ok ? win_id : '0;
            case (state_q)
                IDLE: begin
                    state_q <= any_elig ? ARMED : IDLE;
                    eirq_q  <= any_elig;
                    busy_q  <= 1'b0;
                end
                ARMED: begin
                    if (claim_ok) begin
                        state_q      <= SERVICE;
                        service_id_q <= win_id;
                        eirq_q       <= 1'b0;
                        busy_q       <= 1'b1;
`ifdef IRQ_ARB_RR_PRIORITY_EN
                        ptr_q        <= (win_idx == ID_W'(NUM_SRC - 1)) ? '0 : win_idx + 1'b1;
`endif
                    end else begin
                        state_q <= any_elig ? ARMED : IDLE;
                        eirq_q  <= any_elig;
                        busy_q  <= 1'b0;
                    end
                end
                SERVICE: begin
                    eirq_q <= 1'b0;
                    if (complete_in && complete_id_in == service_id_q) begin
                        state_q      <= IDLE;
                        service_id_q <= '0;
                        busy_q       <= 1'b0;
                    end else begin
                        busy_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    eirq_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_msrv32_irq_arbiter.sv
// tb_msrv32_irq_arbiter: directed self-checking bench for msrv32_irq_arbiter.
module tb_msrv32_irq_arbiter;
    logic       clk = 1'b0, rst = 1'b1;
    logic [7:0] src = '0, en_wdata = '0, enable, pending;
    logic       en_we = 1'b0, claim = 1'b0, claim_ack, complete = 1'b0, eirq, busy;
    logic [3:0] claim_id, complete_id = '0;
    int         n_chk = 0, n_fail = 0;
`ifdef IRQ_ARB_RR_PRIORITY_EN
    localparam logic [3:0] E1 = 4'd6, E2 = 4'd2;
    localparam logic [7:0] P1 = 8'h02;
`else
    localparam logic [3:0] E1 = 4'd2, E2 = 4'd6;
    localparam logic [7:0] P1 = 8'h20;
`endif

    msrv32_irq_arbiter #(.NUM_SRC(8), .ID_W(4)) dut (
        .ms_riscv32_mp_clk_in(clk),
        .ms_riscv32_mp_rst_in(rst),
        .src_in(src),
        .enable_we_in(en_we),
        .enable_wdata_in(en_wdata),
        .enable_out(enable),
        .pending_out(pending),
        .claim_in(claim),
        .claim_ack_out(claim_ack),
        .claim_id_out(claim_id),
        .complete_in(complete),
        .complete_id_in(complete_id),
        .eirq_out(eirq),
        .busy_out(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse(input logic [7:0] m);
        src = m;
        tick();
        src = '0;
        tick();
    endtask

    task automatic do_claim();
        claim = 1'b1;
        tick();
        claim = 1'b0;
    endtask

    task automatic do_complete(input logic [3:0] id);
        complete = 1'b1;
        complete_id = id;
        tick();
        complete = 1'b0;
    endtask

    task automatic write_en(input logic [7:0] m);
        en_we = 1'b1;
        en_wdata = m;
        tick();
        en_we = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        chk("rst_pending", pending, 8'h00);
        chk("rst_enable", enable, 8'h00);
        chk("rst_eirq", eirq, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ack", claim_ack, 0);
        chk("rst_id", claim_id, 0);
        rst = 1'b0;
        write_en(8'hFF);
        chk("enable_ff", enable, 8'hFF);
        // single source, claim
        src = 8'h04;
        tick();
        chk("t1_pending", pending, 8'h04);
        chk("t1_eirq_early", eirq, 0);
        src = 8'h00;
        tick();
        chk("t1_eirq", eirq, 1);
        do_claim();
        chk("t1_ack", claim_ack, 1);
        chk("t1_id", claim_id, 3);
        chk("t1_pend_clr", pending, 8'h00);
        chk("t1_busy", busy, 1);
        chk("t1_eirq_low", eirq, 0);
        tick();
        chk("t1_ack_pulse", claim_ack, 0);
        chk("t1_id_hold", claim_id, 3);
        // rise during service, mismatched then matching complete
        pulse(8'h01);
        chk("t2_eirq_svc", eirq, 0);
        chk("t2_pending", pending, 8'h01);
        do_complete(4'd2);
        chk("t2_mismatch_busy", busy, 1);
        do_complete(4'd3);
        chk("t2_done_busy", busy, 0);
        tick();
        chk("t2_eirq", eirq, 1);
        do_claim();
        chk("t2_id", claim_id, 1);
        do_complete(4'd1);
        // simultaneous rises after a claim of ID 3
        pulse(8'h04);
        do_claim();
        chk("t3_pre_id", claim_id, 3);
        do_complete(4'd3);
        pulse(8'h22);
        chk("t3_eirq", eirq, 1);
        do_claim();
        chk("t3_id1", claim_id, E1);
        chk("t3_pend1", pending, P1);
        do_complete(E1);
        tick();
        do_claim();
        chk("t3_id2", claim_id, E2);
        chk("t3_pend2", pending, 8'h00);
        do_complete(E2);
        // masked pending source
        write_en(8'hEF);
        pulse(8'h10);
        chk("t4_pending", pending, 8'h10);
        chk("t4_eirq_masked", eirq, 0);
        do_claim();
        chk("t4_ack0", claim_ack, 1);
        chk("t4_id0", claim_id, 0);
        chk("t4_busy0", busy, 0);
        write_en(8'hFF);
        chk("t4_eirq_wr", eirq, 0);
        tick();
        chk("t4_eirq_en", eirq, 1);
        do_claim();
        chk("t4_id5", claim_id, 5);
        do_complete(4'd5);
        // rise on the bit being claimed keeps it pending
        pulse(8'h08);
        src = 8'h08;
        do_claim();
        src = 8'h00;
        chk("t5_id", claim_id, 4);
        chk("t5_pending", pending, 8'h08);
        chk("t5_busy", busy, 1);
        // reset during service
        pulse(8'h81);
        chk("t6_pending", pending, 8'h89);
        chk("t6_eirq", eirq, 0);
        rst = 1'b1;
        src = 8'hFF;
        tick();
        chk("t6_rst_pending", pending, 8'h00);
        chk("t6_rst_enable", enable, 8'h00);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_id", claim_id, 0);
        chk("t6_rst_eirq", eirq, 0);
        rst = 1'b0;
        tick();
        tick();
        chk("t6_held_pending", pending, 8'h00);
        chk("t6_held_busy", busy, 0);
        src = 8'h00;
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
